// File: rtl/branch_resolve_if.sv
// Handshake/flag bundle between the issue/flag logic and branch_resolve.
// master drives requests and flags; slave returns ready and redirect.
interface branch_resolve_if #(
    parameter int W = 16
);
    logic         flag_issue;
    logic         flag_commit;
    logic         N_flag;
    logic         Z_flag;
    logic         V_flag;
    logic         br_valid;
    logic [2:0]   br_cond;
    logic [W-1:0] br_target;
    logic [W-1:0] br_fallthru;
    logic         flush;
    logic         br_ready;
    logic         redir_valid;
    logic         redir_taken;
    logic [W-1:0] redir_pc;
    logic         pend_err;

    modport master (
        output flag_issue, flag_commit,
        output N_flag, Z_flag, V_flag,
        output br_valid, br_cond, br_target, br_fallthru, flush,
        input  br_ready, redir_valid, redir_taken, redir_pc, pend_err
    );

    modport slave (
        input  flag_issue, flag_commit,
        input  N_flag, Z_flag, V_flag,
        input  br_valid, br_cond, br_target, br_fallthru, flush,
        output br_ready, redir_valid, redir_taken, redir_pc, pend_err
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution: holds a branch until all flag writers commit, then redirects.
// Optional BRANCH_STATS_EN adds taken_cnt/stall_cnt counters.
module branch_resolve #(
    parameter int W        = 16,
    parameter int MAX_PEND = 3
) (
    input  logic            clk,
    input  logic            rst,
    branch_resolve_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     taken_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int CW = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] pend_cnt;
    logic          pend_err_q;
    logic          rdy_q;
    logic [2:0]    cond_q;
    logic [W-1:0]  tgt_q;
    logic [W-1:0]  ft_q;
    logic          cond_true;
    logic          no_pend;
    logic          fire;

    assign no_pend = (pend_cnt == '0);

    // Outstanding flag-writer scoreboard; saturates high, floors at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt   <= '0;
            pend_err_q <= 1'b0;
        end else begin
            unique case ({bus.flag_issue, bus.flag_commit})
                2'b10: begin
                    if (pend_cnt == CNT_MAX)
                        pend_err_q <= 1'b1;
                    else
                        pend_cnt <= pend_cnt + 1'b1;
                end
                2'b01: begin
                    if (!no_pend)
                        pend_cnt <= pend_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Branch capture / wait / resolve sequencing with registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rdy_q  <= 1'b1;
            cond_q <= '0;
            tgt_q  <= '0;
            ft_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.br_valid && !bus.flush) begin
                        cond_q <= bus.br_cond;
                        tgt_q  <= bus.br_target;
                        ft_q   <= bus.br_fallthru;
                        rdy_q  <= 1'b0;
                        state  <= no_pend ? S_RESOLVE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                        rdy_q <= 1'b1;
                    end else if (no_pend) begin
                        state <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    state <= S_IDLE;
                    rdy_q <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    // Condition evaluation on the live flag register outputs.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond_q)
            3'b000: cond_true = !bus.Z_flag;
            3'b001: cond_true = bus.Z_flag;
            3'b010: cond_true = !bus.Z_flag && !bus.N_flag;
            3'b011: cond_true = bus.N_flag;
            3'b100: cond_true = bus.Z_flag || (!bus.Z_flag && !bus.N_flag);
            3'b101: cond_true = bus.N_flag || bus.Z_flag;
            3'b110: cond_true = bus.V_flag;
            3'b111: cond_true = 1'b1;
        endcase
    end

    assign fire = (state == S_RESOLVE) && !bus.flush;

    assign bus.br_ready    = rdy_q;
    assign bus.redir_valid = fire;
    assign bus.redir_taken = fire && cond_true;
    assign bus.redir_pc    = !fire    ? '0    :
                             cond_true ? tgt_q : ft_q;
    assign bus.pend_err    = pend_err_q;

`ifdef BRANCH_STATS_EN
    // Taken redirects and WAIT-cycle stalls, both free-running wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == S_WAIT)
                stall_cnt <= stall_cnt + 16'd1;
            if (fire && cond_true)
                taken_cnt <= taken_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a cycle-level reference model.
// Builds with or without BRANCH_STATS_EN.
module tb_branch_resolve;

    localparam int W        = 16;
    localparam int MAX_PEND = 3;

    logic clk;
    logic rst;

    branch_resolve_if #(.W(W)) bus ();

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] stall_cnt;
`endif

    branch_resolve #(.W(W), .MAX_PEND(MAX_PEND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt (taken_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: pending writers as an integer, plus a held branch
    // record and a flag saying the held branch redirects this cycle.
    int          m_cnt;
    bit          m_err;
    bit          m_held;
    bit          m_go;
    logic [2:0]  m_cond;
    logic [15:0] m_tgt;
    logic [15:0] m_ft;
`ifdef BRANCH_STATS_EN
    logic [15:0] m_taken;
    logic [15:0] m_stall;
`endif

    function automatic bit cond_eval(input logic [2:0] c,
                                     input bit n, input bit z, input bit v);
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_err  <= 1'b0;
            m_held <= 1'b0;
            m_go   <= 1'b0;
            m_cond <= '0;
            m_tgt  <= '0;
            m_ft   <= '0;
`ifdef BRANCH_STATS_EN
            m_taken <= '0;
            m_stall <= '0;
`endif
        end else begin
`ifdef BRANCH_STATS_EN
            if (m_held && !m_go)
                m_stall <= m_stall + 16'd1;
            if (m_go && !bus.flush &&
                cond_eval(m_cond, bus.N_flag, bus.Z_flag, bus.V_flag))
                m_taken <= m_taken + 16'd1;
`endif
            if (m_go) begin
                m_go   <= 1'b0;
                m_held <= 1'b0;
            end else if (m_held) begin
                if (bus.flush)
                    m_held <= 1'b0;
                else if (m_cnt == 0)
                    m_go <= 1'b1;
            end else if (bus.br_valid && !bus.flush) begin
                m_held <= 1'b1;
                m_go   <= (m_cnt == 0);
                m_cond <= bus.br_cond;
                m_tgt  <= bus.br_target;
                m_ft   <= bus.br_fallthru;
            end
            if (bus.flag_issue && !bus.flag_commit) begin
                if (m_cnt == MAX_PEND)
                    m_err <= 1'b1;
                else
                    m_cnt <= m_cnt + 1;
            end else if (bus.flag_commit && !bus.flag_issue && m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            bit          e_v;
            bit          e_t;
            logic [15:0] e_pc;
            e_v  = m_go && !bus.flush;
            e_t  = e_v && cond_eval(m_cond, bus.N_flag, bus.Z_flag, bus.V_flag);
            e_pc = !e_v ? 16'h0 : (e_t ? m_tgt : m_ft);
            chk("m_br_ready",    32'(bus.br_ready),    32'(!m_held));
            chk("m_redir_valid", 32'(bus.redir_valid), 32'(e_v));
            chk("m_redir_taken", 32'(bus.redir_taken), 32'(e_t));
            chk("m_redir_pc",    32'(bus.redir_pc),    32'(e_pc));
            chk("m_pend_err",    32'(bus.pend_err),    32'(m_err));
`ifdef BRANCH_STATS_EN
            chk("m_taken_cnt",   32'(taken_cnt),       32'(m_taken));
            chk("m_stall_cnt",   32'(stall_cnt),       32'(m_stall));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.flag_issue  = 1'b0;
        bus.flag_commit = 1'b0;
        bus.br_valid    = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic branch(input logic [2:0] c, input logic [15:0] t,
                          input logic [15:0] f);
        bus.br_valid    = 1'b1;
        bus.br_cond     = c;
        bus.br_target   = t;
        bus.br_fallthru = f;
    endtask

    logic [7:0] masks [8];

    initial begin
        masks = '{8'h33, 8'hCC, 8'h03, 8'hF0, 8'hCF, 8'hFC, 8'hAA, 8'hFF};
        rst             = 1'b1;
        bus.flag_issue  = 1'b0;
        bus.flag_commit = 1'b0;
        bus.N_flag      = 1'b0;
        bus.Z_flag      = 1'b0;
        bus.V_flag      = 1'b0;
        bus.br_valid    = 1'b0;
        bus.br_cond     = '0;
        bus.br_target   = '0;
        bus.br_fallthru = '0;
        bus.flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_br_ready",    32'(bus.br_ready),    32'd1);
        chk("rst_redir_valid", 32'(bus.redir_valid), 32'd0);
        chk("rst_redir_taken", 32'(bus.redir_taken), 32'd0);
        chk("rst_redir_pc",    32'(bus.redir_pc),    32'd0);
        chk("rst_pend_err",    32'(bus.pend_err),    32'd0);

        // no pending writers: one-cycle resolve
        bus.Z_flag = 1'b1;
        branch(3'b001, 16'h0040, 16'h0012);
        tick();
        chk("t1_valid",    32'(bus.redir_valid), 32'd1);
        chk("t1_taken",    32'(bus.redir_taken), 32'd1);
        chk("t1_pc",       32'(bus.redir_pc),    32'h0040);
        chk("t1_notready", 32'(bus.br_ready),    32'd0);
        tick();
        chk("t1_ready", 32'(bus.br_ready), 32'd1);

        // two writers in flight, commits at A+2 and A+4
        bus.N_flag = 1'b1;
        bus.Z_flag = 1'b0;
        bus.flag_issue = 1'b1;
        tick();
        bus.flag_issue = 1'b1;
        tick();
        branch(3'b011, 16'h0200, 16'h0102);
        tick();
        tick();
        bus.flag_commit = 1'b1;
        tick();
        tick();
        bus.flag_commit = 1'b1;
        tick();
        chk("t2_hold", 32'(bus.redir_valid), 32'd0);
        tick();
        chk("t2_valid", 32'(bus.redir_valid), 32'd1);
        chk("t2_taken", 32'(bus.redir_taken), 32'd1);
        chk("t2_pc",    32'(bus.redir_pc),    32'h0200);
        tick();
`ifdef BRANCH_STATS_EN
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("t2_taken_cnt", 32'(taken_cnt), 32'd2);
`endif

        // simultaneous issue+commit leaves count at 1
        bus.flag_issue = 1'b1;
        tick();
        branch(3'b111, 16'h0300, 16'h0202);
        tick();
        bus.flag_issue  = 1'b1;
        bus.flag_commit = 1'b1;
        tick();
        bus.flag_issue  = 1'b1;
        bus.flag_commit = 1'b1;
        tick();
        chk("t3_wait_rdy", 32'(bus.br_ready),    32'd0);
        chk("t3_wait_v",   32'(bus.redir_valid), 32'd0);
        bus.flag_commit = 1'b1;
        tick();
        chk("t3_hold", 32'(bus.redir_valid), 32'd0);
        tick();
        chk("t3_valid", 32'(bus.redir_valid), 32'd1);
        chk("t3_pc",    32'(bus.redir_pc),    32'h0300);
        tick();

        // flush in WAIT, flush with request in IDLE, flush in RESOLVE
        bus.flag_issue = 1'b1;
        tick();
        branch(3'b111, 16'h0400, 16'h0302);
        tick();
        bus.flush = 1'b1;
        tick();
        chk("t4_ready", 32'(bus.br_ready),    32'd1);
        chk("t4_valid", 32'(bus.redir_valid), 32'd0);
        bus.flag_commit = 1'b1;
        tick();
        branch(3'b111, 16'h0500, 16'h0402);
        bus.flush = 1'b1;
        tick();
        chk("t4_nocap_rdy", 32'(bus.br_ready),    32'd1);
        chk("t4_nocap_v",   32'(bus.redir_valid), 32'd0);
        tick();
        branch(3'b111, 16'h0600, 16'h0502);
        tick();
        bus.flush = 1'b1;
        #1;
        chk("t4_res_flush_v", 32'(bus.redir_valid), 32'd0);
        tick();
        chk("t4_res_flush_rdy", 32'(bus.br_ready), 32'd1);

        // saturation and sticky error; commit at zero floors
        repeat (4) begin
            bus.flag_issue = 1'b1;
            tick();
        end
        chk("t5_err", 32'(bus.pend_err), 32'd1);
        repeat (3) begin
            bus.flag_commit = 1'b1;
            tick();
        end
        chk("t5_err_sticky", 32'(bus.pend_err), 32'd1);
        branch(3'b111, 16'h0700, 16'h0602);
        tick();
        chk("t5_drained", 32'(bus.redir_valid), 32'd1);
        tick();
        bus.flag_commit = 1'b1;
        tick();
        bus.flag_issue = 1'b1;
        tick();
        branch(3'b111, 16'h0800, 16'h0702);
        tick();
        chk("t5_floor_wait", 32'(bus.redir_valid), 32'd0);
        bus.flag_commit = 1'b1;
        tick();
        tick();
        chk("t5_floor_v", 32'(bus.redir_valid), 32'd1);
        tick();

        // condition sweep
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                logic [7:0]  m;
                logic [2:0]  nzv;
                logic [15:0] tg;
                logic [15:0] ft;
                m   = masks[c];
                nzv = 3'(f);
                tg  = 16'h1000 + 16'(c * 8 + f);
                ft  = 16'h2000 + 16'(c * 8 + f);
                bus.N_flag = nzv[2];
                bus.Z_flag = nzv[1];
                bus.V_flag = nzv[0];
                branch(3'(c), tg, ft);
                tick();
                chk("sw_valid", 32'(bus.redir_valid), 32'd1);
                chk("sw_taken", 32'(bus.redir_taken), 32'(m[f]));
                chk("sw_pc",    32'(bus.redir_pc),    32'(m[f] ? tg : ft));
                tick();
            end
        end
        bus.N_flag = 1'b0;
        bus.Z_flag = 1'b0;
        bus.V_flag = 1'b0;
        branch(3'b110, 16'h0A00, 16'h0902);
        tick();
        chk("t6_v0_pc", 32'(bus.redir_pc), 32'h0902);
        tick();

        // async reset in WAIT
        bus.flag_issue = 1'b1;
        tick();
        branch(3'b111, 16'h0B00, 16'h0A02);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t7_rdy",   32'(bus.br_ready),    32'd1);
        chk("t7_valid", 32'(bus.redir_valid), 32'd0);
        chk("t7_err",   32'(bus.pend_err),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef BRANCH_STATS_EN
        chk("t7_stall0", 32'(stall_cnt), 32'd0);
        chk("t7_taken0", 32'(taken_cnt), 32'd0);
`endif
        branch(3'b111, 16'h0C00, 16'h0B02);
        tick();
        chk("t7_post_v",  32'(bus.redir_valid), 32'd1);
        chk("t7_post_pc", 32'(bus.redir_pc),    32'h0C00);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
